// File: rtl/sys_structs.sv
// sys_structs: shared types for the asynchronous event scheduler
//   edge_mode_t   - per-channel trigger selection (RISE, FALL, BOTH, NONE)
//   sched_state_t - scheduler FSM states (PRIME, RUN)
//   edge_match    - does a debounced transition to lvl fire under mode m
package sys_structs;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_NONE = 2'd3
    } edge_mode_t;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_t;

    function automatic logic edge_match(input edge_mode_t m, input logic lvl);
        return (lvl && (m == EDGE_RISE || m == EDGE_BOTH)) ||
               (!lvl && (m == EDGE_FALL || m == EDGE_BOTH));
    endfunction

endpackage

// File: rtl/synchronization_chain.sv
// synchronization_chain: unreset multi-flop synchronizer, one chain per bit
//   clk - destination clock
//   d_i - raw asynchronous levels
//   q_o - levels after CHAIN_DEPTH flops
module synchronization_chain #(
    parameter int CHAIN_DEPTH = 3,
    parameter int CHAIN_WIDTH = 4
) (
    input  logic                   clk,
    input  logic [CHAIN_WIDTH-1:0] d_i,
    output logic [CHAIN_WIDTH-1:0] q_o
);

    // No reset: the scheduler's PRIME phase flushes whatever these power up to.
    logic [CHAIN_DEPTH-1:0][CHAIN_WIDTH-1:0] chain_q;

    always_ff @(posedge clk) begin
        chain_q <= {chain_q[CHAIN_DEPTH-2:0], d_i};
    end

    assign q_o = chain_q[CHAIN_DEPTH-1];

endmodule

// File: rtl/async_event_scheduler.sv
// async_event_scheduler: synchronize, debounce and round-robin report edges on async channels
//   clk, async_rst_n   - clock, asynchronous active-low reset
//   clk_en             - freezes all state except the synchronizers when low
//   async_i            - raw asynchronous levels
//   chan_en_i          - per-channel event enable
//   edge_mode_i        - per-channel edge_mode_t, channel i at [2*i+1:2*i]
//   evt_valid_o/evt_ready_i/evt_channel_o/evt_level_o - event handshake
//   overflow_o/overflow_clr_i - sticky lost-event flags and their clear
//   stable_o           - debounced levels
module async_event_scheduler
    import sys_structs::*;
#(
    parameter int  CHANNELS        = 4,
    parameter int  SYNC_DEPTH      = 3,
    parameter int  DEBOUNCE_CYCLES = 8,
    localparam int CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  clk_en,
    input  logic [CHANNELS-1:0]   async_i,
    input  logic [CHANNELS-1:0]   chan_en_i,
    input  logic [2*CHANNELS-1:0] edge_mode_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [CW-1:0]         evt_channel_o,
    output logic                  evt_level_o,
    output logic [CHANNELS-1:0]   overflow_o,
    input  logic [CHANNELS-1:0]   overflow_clr_i,
    output logic [CHANNELS-1:0]   stable_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PW = $clog2(SYNC_DEPTH + 1) + 1;

    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] upd, hit, gnt_oh;
    logic [CW-1:0]       gnt_idx;
    logic                found, grant;

    sched_state_t        state_q, state_d;
    logic [PW-1:0]       prime_q, prime_d;
    logic [CHANNELS-1:0] stable_q, stable_d;
    logic [DW-1:0]       cnt_q [CHANNELS];
    logic [DW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic                lvl_q, lvl_d;
    logic [CW-1:0]       last_q, last_d;

    synchronization_chain #(
        .CHAIN_DEPTH(SYNC_DEPTH),
        .CHAIN_WIDTH(CHANNELS)
    ) u_sync (
        .clk (clk),
        .d_i (async_i),
        .q_o (synced)
    );

    // A channel's debounced level flips on the edge its counter saturates.
    always_comb begin
        upd = '0;
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            upd[i] = (synced[i] != stable_q[i]) && (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1));
            hit[i] = upd[i] && chan_en_i[i] &&
                     edge_match(edge_mode_t'(edge_mode_i[2*i +: 2]), synced[i]);
        end
    end

    // Round-robin: first pending channel after the last granted one.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!found && pend_q[CW'((int'(last_q) + k) % CHANNELS)]) begin
                found   = 1'b1;
                gnt_idx = CW'((int'(last_q) + k) % CHANNELS);
            end
        end
        grant  = found && (!valid_q || evt_ready_i);
        gnt_oh = grant ? (CHANNELS'(1) << gnt_idx) : '0;
    end

    always_comb begin
        state_d  = state_q;
        prime_d  = prime_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q & ~overflow_clr_i;
        valid_d  = valid_q;
        ch_d     = ch_q;
        lvl_d    = lvl_q;
        last_d   = last_q;
        if (state_q == ST_PRIME) begin
            stable_d = synced;
            pend_d   = '0;
            for (int i = 0; i < CHANNELS; i++) cnt_d[i] = '0;
            if (prime_q == PW'(SYNC_DEPTH)) state_d = ST_RUN;
            else prime_d = prime_q + 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_d[i] = (synced[i] == stable_q[i] || upd[i]) ? '0 : cnt_q[i] + 1'b1;
                if (upd[i]) stable_d[i] = synced[i];
                // A grant and a fresh edge on one edge simply keep the bit pending.
                pend_d[i] = chan_en_i[i] && ((pend_q[i] && !gnt_oh[i]) || hit[i]);
                if (hit[i] && pend_q[i] && !gnt_oh[i]) ovf_d[i] = 1'b1;
            end
        end
        if (grant) begin
            valid_d = 1'b1;
            ch_d    = gnt_idx;
            lvl_d   = stable_q[gnt_idx];
            last_d  = gnt_idx;
        end else if (evt_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q  <= ST_PRIME;
            prime_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
            pend_q   <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            lvl_q    <= 1'b0;
            last_q   <= CW'(CHANNELS - 1);
        end else if (clk_en) begin
            state_q  <= state_d;
            prime_q  <= prime_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            lvl_q    <= lvl_d;
            last_q   <= last_d;
        end
    end

    assign evt_valid_o   = valid_q;
    assign evt_channel_o = ch_q;
    assign evt_level_o   = lvl_q;
    assign overflow_o    = ovf_q;
    assign stable_o      = stable_q;

endmodule
